// File: rtl/vga_line_buffer_if.sv
// Write port of the VGA line buffer: a producer pushes 12-bit 4:4:4 pixels into
// the bank that is not being displayed.
`timescale 1ns/1ps

// Handshake: a pixel transfers on a clk edge where wr_valid and wr_ready are both 1.
// The producer holds wr_valid and wr_data stable until that edge. wr_ready does not
// depend on wr_valid, and it stays low while the write bank is full or in reset.
interface vga_line_buffer_if;
   logic        wr_valid;
   logic [11:0] wr_data;
   logic        wr_ready;

   modport master (output wr_valid, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer feeding registered 4:4:4 RGB to the SVGA timing stage.
// Optional colour-bar generator is enabled by defining VGA_LB_PATTERN_EN.
`timescale 1ns/1ps

module vga_line_buffer #(
   parameter int H_VISIBLE = 800,
   parameter int ADDR_W    = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pix_tick,
   input  logic                line_start,
   input  logic                h_active,
`ifdef VGA_LB_PATTERN_EN
   input  logic                pattern_sel,
`endif
   vga_line_buffer_if.slave    wr,
   output logic [3:0]          red,
   output logic [3:0]          green,
   output logic [3:0]          blue,
   output logic                underflow
);

   localparam logic [ADDR_W-1:0] PTR_FULL = ADDR_W'(H_VISIBLE);
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(H_VISIBLE - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [11:0]       bank0 [H_VISIBLE];
   logic [11:0]       bank1 [H_VISIBLE];

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              disp_bank;
   logic              disp_valid;

   logic              accept;
   logic              full;
   logic              ls_tick;
   logic              rd_tick;

   logic              s1_en;
   logic              s1_show;
   logic              s1_pat;
   logic [2:0]        s1_bar;
   logic [11:0]       s1_data;
   logic [11:0]       rgb;
   logic [11:0]       pat_rgb;
   logic              pat_req;

   assign wr.wr_ready = (wr_ptr < PTR_FULL) && !rst;
   assign accept      = wr.wr_valid && wr.wr_ready;
   // A write landing on the last entry in the same clk as line_start still counts.
   assign full        = (wr_ptr == PTR_FULL) || (accept && (wr_ptr == PTR_LAST));
   assign ls_tick     = pix_tick && line_start;
   assign rd_tick     = pix_tick && h_active;

`ifdef VGA_LB_PATTERN_EN
   assign pat_req = rd_tick && pattern_sel;
`else
   assign pat_req = 1'b0;
`endif

   function automatic logic [2:0] bar_of(input logic [ADDR_W-1:0] p);
      logic [2:0] b;
      b = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (p >= ADDR_W'(i * 100)) b = 3'(i);
      end
      return b;
   endfunction

   // Pointers, bank ownership and the sticky underflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         disp_bank  <= 1'b0;
         disp_valid <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (ls_tick && full) begin
            disp_bank  <= ~disp_bank;
            disp_valid <= 1'b1;
            wr_ptr     <= '0;
         end else if (accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end

         if (ls_tick) begin
            rd_ptr <= '0;
            if (!full) underflow <= 1'b1;
         end else if (rd_tick && (rd_ptr != PTR_LAST)) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Line RAM: written into the bank not on display, read every pixel tick.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (disp_bank) bank0[wr_ptr] <= wr.wr_data;
         else           bank1[wr_ptr] <= wr.wr_data;
      end
      if (pix_tick) begin
         s1_data <= disp_bank ? bank1[rd_ptr] : bank0[rd_ptr];
      end
   end

   // Stage 1 carries the per-tick qualifiers alongside the RAM read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_en   <= 1'b0;
         s1_show <= 1'b0;
         s1_pat  <= 1'b0;
         s1_bar  <= 3'd0;
      end else begin
         s1_en   <= pix_tick;
         s1_show <= rd_tick && disp_valid;
         s1_pat  <= pat_req;
         s1_bar  <= bar_of(rd_ptr);
      end
   end

   always_comb begin
      pat_rgb = {{4{s1_bar[2]}}, {4{s1_bar[1]}}, {4{s1_bar[0]}}};
   end

   // Stage 2: output register, updated only by a tick and held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb <= 12'h000;
      end else if (s1_en) begin
         if (s1_pat)       rgb <= pat_rgb;
         else if (s1_show) rgb <= s1_data;
         else              rgb <= 12'h000;
      end
   end

   assign red   = rgb[11:8];
   assign green = rgb[7:4];
   assign blue  = rgb[3:0];

endmodule
